freq_stream_packer: RTL and testbench

Receiving end of the frequency-selector AXI stream. Accepts 80-bit selected-tone samples with `{index[6:0], k[13:0]}` in `tuser`, buffers them in a small FIFO, and serialises each sample into four 32-bit words (one header, three data) on a 32-bit AXI-stream master for the DMA. The upstream selector does not honour `tready`, so samples that arrive while the FIFO is full are dropped whole and counted.

---
 rtl/freq_stream_packer.sv | 162 ++++++++++++++++
 tb/tb_freq_stream_packer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_stream_packer.sv
// Buffers 80-bit selector samples in a FIFO and serialises each one into
// a header word plus three data words on a 32-bit AXI-stream master.
module freq_stream_packer #(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [3:0] HDR_TAG    = 4'hA
) (
  input  logic        dev_clk,
  input  logic        dev_rst,
  input  logic [79:0] s_axis_tdata,
  input  logic [20:0] s_axis_tuser,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] drop_count,
  output logic [15:0] frame_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 102;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_D0,
    ST_D1,
    ST_D2
  } state_t;

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [80:0]   r_hold;
  state_t        r_state;
  logic [31:0]   r_tdata;
  logic          r_tvalid;
  logic          r_tlast;
  logic [15:0]   r_drop;
  logic [15:0]   r_frame;

  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_drop;
  logic          w_hs;
  logic          w_pop;
  logic [EW-1:0] w_head;
  logic [31:0]   w_hdr;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_wr    = s_axis_tvalid && !w_full;
  assign w_drop  = s_axis_tvalid && w_full;
  assign w_hs    = r_tvalid && m_axis_tready;
  // Pop from IDLE, or straight out of D2 so back-to-back samples have no bubble
  assign w_pop   = !w_empty &&
                   ((r_state == ST_IDLE) ||
                    ((r_state == ST_D2) && w_hs));
  assign w_head  = r_mem[r_rptr];
  assign w_hdr   = {HDR_TAG, 7'b0, w_head[100:94], w_head[93:80]};

  assign s_axis_tready = !w_full;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign drop_count    = r_drop;
  assign frame_count   = r_frame;

  always_ff @(posedge dev_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= {s_axis_tlast, s_axis_tuser, s_axis_tdata};
    end
  end

  always_ff @(posedge dev_clk or posedge dev_rst) begin
    if (dev_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge dev_clk or posedge dev_rst) begin
    if (dev_rst) begin
      r_drop  <= '0;
      r_frame <= '0;
    end else begin
      if (w_drop && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
      if (w_wr && s_axis_tlast) begin
        r_frame <= r_frame + 16'd1;
      end
    end
  end

  always_ff @(posedge dev_clk or posedge dev_rst) begin
    if (dev_rst) begin
      r_state  <= ST_IDLE;
      r_hold   <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (w_pop) begin
      r_hold   <= {w_head[101], w_head[79:0]};
      r_tdata  <= w_hdr;
      r_tvalid <= 1'b1;
      r_tlast  <= 1'b0;
      r_state  <= ST_HDR;
    end else begin
      unique case (r_state)
        ST_IDLE: ;
        ST_HDR: begin
          if (w_hs) begin
            r_tdata <= r_hold[31:0];
            r_state <= ST_D0;
          end
        end
        ST_D0: begin
          if (w_hs) begin
            r_tdata <= r_hold[63:32];
            r_state <= ST_D1;
          end
        end
        ST_D1: begin
          if (w_hs) begin
            r_tdata <= {16'h0000, r_hold[79:64]};
            r_tlast <= r_hold[80];
            r_state <= ST_D2;
          end
        end
        ST_D2: begin
          if (w_hs) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_stream_packer.sv
// Bench for freq_stream_packer: directed vector table, corner sequences and
// random traffic, all checked against a transaction-level queue model.
module tb_freq_stream_packer;

  localparam int D = 16;

  logic        dev_clk = 1'b0;
  logic        dev_rst;
  logic [79:0] s_axis_tdata;
  logic [20:0] s_axis_tuser;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [15:0] drop_count;
  logic [15:0] frame_count;

  freq_stream_packer #(.FIFO_DEPTH(D), .HDR_TAG(4'hA)) dut (
    .dev_clk      (dev_clk),
    .dev_rst      (dev_rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .drop_count   (drop_count),
    .frame_count  (frame_count)
  );

  always #5 dev_clk = ~dev_clk;

  typedef struct packed {
    logic [127:0] w;
    logic         last;
  } smp_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
    int          c;
  } beat_t;

  typedef struct {
    logic [79:0] d;
    logic [6:0]  idx;
    logic [13:0] k;
    logic        last;
    logic [31:0] w0, w1, w2, w3;
  } vec_t;

  smp_t        mq[$];
  smp_t        cur;
  int          wl;
  logic [15:0] m_drop;
  logic [15:0] m_frame;
  beat_t       got[$];
  int          cyc;
  int          checks;
  int          errors;
  vec_t        tbl[4];

  function automatic logic [127:0] mk(logic [79:0] d, logic [6:0] idx,
                                      logic [13:0] k);
    logic [31:0] h;
    h = 32'hA000_0000 + (32'(idx) << 14) + 32'(k);
    return {{16'h0000, d[79:64]}, d[63:32], d[31:0], h};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h",
               name, cyc, act, exp);
    end
  endtask

  // One clock: compare DUT against model, advance model, take the edge
  task automatic cycle();
    int   sz;
    smp_t s;
    sz = mq.size();
    chk("tvalid", 64'(m_axis_tvalid), 64'(wl > 0));
    if (wl > 0) begin
      chk("tdata", 64'(m_axis_tdata), 64'(cur.w[32*(4-wl) +: 32]));
      chk("tlast", 64'(m_axis_tlast), 64'((wl == 1) && cur.last));
    end else begin
      chk("idle_out", 64'({m_axis_tlast, m_axis_tdata}), 64'(0));
    end
    chk("s_tready", 64'(s_axis_tready), 64'(sz != D));
    if (m_axis_tvalid && m_axis_tready) begin
      got.push_back('{d: m_axis_tdata, l: m_axis_tlast, c: cyc});
    end
    if (wl > 0 && m_axis_tready) wl--;
    if (wl == 0 && sz > 0) begin
      cur = mq.pop_front();
      wl = 4;
    end
    if (s_axis_tvalid) begin
      if (sz != D) begin
        s.w = mk(s_axis_tdata, s_axis_tuser[20:14], s_axis_tuser[13:0]);
        s.last = s_axis_tlast;
        mq.push_back(s);
        if (s_axis_tlast) m_frame++;
      end else if (m_drop != 16'hFFFF) begin
        m_drop++;
      end
    end
    @(posedge dev_clk);
    #1;
    cyc++;
  endtask

  task automatic set_in(logic [79:0] d, logic [6:0] idx, logic [13:0] k,
                        logic last);
    s_axis_tdata  = d;
    s_axis_tuser  = {idx, k};
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
  endtask

  task automatic set_rand();
    set_in({$urandom, $urandom, $urandom}, 7'($urandom), 14'($urandom),
           1'($urandom));
  endtask

  task automatic send(logic [79:0] d, logic [6:0] idx, logic [13:0] k,
                      logic last);
    set_in(d, idx, k, last);
    cycle();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain(int max);
    int n;
    n = 0;
    while ((wl != 0 || mq.size() != 0) && n < max) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 64'(wl != 0 || mq.size() != 0), 64'(0));
    repeat (2) cycle();
  endtask

  task automatic wait_words(int n, int max);
    int i;
    i = 0;
    while (got.size() < n && i < max) begin
      cycle();
      i++;
    end
    chk("words_timeout", 64'(got.size() < n), 64'(0));
  endtask

  task automatic check_counts(string tag);
    chk({tag, "_drop"}, 64'(drop_count), 64'(m_drop));
    chk({tag, "_frame"}, 64'(frame_count), 64'(m_frame));
  endtask

  initial begin
    int          acc;
    int          n;
    logic [11:0] lv;

    tbl[0] = '{80'h1234_89ABCDEF_01234567, 7'd5, 14'd100, 1'b1,
               32'hA0014064, 32'h01234567, 32'h89ABCDEF, 32'h00001234};
    tbl[1] = '{{80{1'b1}}, 7'd127, 14'h3FFF, 1'b0,
               32'hA01FFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF};
    tbl[2] = '{80'h0, 7'd0, 14'd0, 1'b1,
               32'hA0000000, 32'h0, 32'h0, 32'h0};
    tbl[3] = '{80'hDEAD_CAFEBABE_0BADF00D, 7'd42, 14'h1555, 1'b0,
               32'hA00A9555, 32'h0BADF00D, 32'hCAFEBABE, 32'h0000DEAD};

    checks = 0;
    errors = 0;
    cyc = 0;
    wl = 0;
    m_drop = '0;
    m_frame = '0;
    s_axis_tdata = '0;
    s_axis_tuser = '0;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    dev_rst = 1'b1;

    @(posedge dev_clk);
    #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_tdata", 64'(m_axis_tdata), 64'(0));
    chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
    chk("rst_s_tready", 64'(s_axis_tready), 64'(1));
    chk("rst_drop", 64'(drop_count), 64'(0));
    chk("rst_frame", 64'(frame_count), 64'(0));
    dev_rst = 1'b0;
    repeat (2) cycle();

    for (int i = 0; i < 4; i++) begin
      got.delete();
      acc = cyc;
      send(tbl[i].d, tbl[i].idx, tbl[i].k, tbl[i].last);
      wait_words(4, 20);
      if (got.size() >= 4) begin
        chk("tbl_w0", 64'(got[0].d), 64'(tbl[i].w0));
        chk("tbl_w1", 64'(got[1].d), 64'(tbl[i].w1));
        chk("tbl_w2", 64'(got[2].d), 64'(tbl[i].w2));
        chk("tbl_w3", 64'(got[3].d), 64'(tbl[i].w3));
        chk("tbl_last", 64'({got[0].l, got[1].l, got[2].l, got[3].l}),
            64'({3'b000, tbl[i].last}));
        chk("tbl_latency", 64'(got[0].c), 64'(acc + 2));
      end
      drain(20);
      if (i == 0) chk("tbl_frame1", 64'(frame_count), 64'(1));
    end
    chk("tbl_frame", 64'(frame_count), 64'(2));

    got.delete();
    for (int i = 0; i < 8; i++) begin
      set_rand();
      cycle();
    end
    s_axis_tvalid = 1'b0;
    wait_words(32, 100);
    chk("burst_n", 64'(got.size()), 64'(32));
    if (got.size() >= 32) begin
      chk("burst_gap", 64'(got[31].c - got[0].c), 64'(31));
    end
    chk("burst_drop", 64'(drop_count), 64'(0));
    drain(100);
    check_counts("burst");

    // Stalled output: one sample parks in the holding register, 16 in FIFO
    m_axis_tready = 1'b0;
    got.delete();
    for (int i = 0; i < 20; i++) begin
      set_rand();
      cycle();
    end
    s_axis_tvalid = 1'b0;
    chk("ovf_drop", 64'(drop_count), 64'(3));
    m_axis_tready = 1'b1;
    wait_words(68, 400);
    chk("ovf_words", 64'(got.size()), 64'(68));
    drain(100);
    check_counts("ovf");

    got.delete();
    for (int i = 0; i < 3; i++) begin
      set_rand();
      s_axis_tlast = (i == 2);
      m_axis_tready = 1'($urandom);
      cycle();
    end
    s_axis_tvalid = 1'b0;
    n = 0;
    while (got.size() < 12 && n < 200) begin
      m_axis_tready = 1'($urandom);
      cycle();
      n++;
    end
    m_axis_tready = 1'b1;
    drain(50);
    chk("bp_n", 64'(got.size()), 64'(12));
    lv = '0;
    for (int i = 0; i < got.size() && i < 12; i++) lv[i] = got[i].l;
    chk("bp_last", 64'(lv), 64'(12'h800));

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 40) set_rand();
      else s_axis_tvalid = 1'b0;
      m_axis_tready = ($urandom_range(0, 99) < 70);
      cycle();
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    drain(200);
    check_counts("rand");

    for (int i = 0; i < 3; i++) begin
      set_rand();
      cycle();
    end
    s_axis_tvalid = 1'b0;
    n = 0;
    while (wl != 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("rst_reach_d1", 64'(wl), 64'(2));
    #2;
    dev_rst = 1'b1;
    #1;
    chk("arst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("arst_tdata", 64'(m_axis_tdata), 64'(0));
    chk("arst_tlast", 64'(m_axis_tlast), 64'(0));
    chk("arst_s_tready", 64'(s_axis_tready), 64'(1));
    chk("arst_drop", 64'(drop_count), 64'(0));
    chk("arst_frame", 64'(frame_count), 64'(0));
    @(posedge dev_clk);
    #1;
    dev_rst = 1'b0;
    mq.delete();
    wl = 0;
    m_drop = '0;
    m_frame = '0;
    cyc++;
    got.delete();
    repeat (3) cycle();
    send(tbl[3].d, tbl[3].idx, tbl[3].k, tbl[3].last);
    drain(20);
    chk("post_rst_n", 64'(got.size()), 64'(4));
    if (got.size() >= 1) chk("post_rst_hdr", 64'(got[0].d), 64'(tbl[3].w0));

    force dut.r_frame = 16'hFFFF;
    @(posedge dev_clk);
    #1;
    release dut.r_frame;
    cyc++;
    m_frame = 16'hFFFF;
    chk("wrap_pre", 64'(frame_count), 64'(16'hFFFF));
    send(80'h5, 7'd1, 14'd2, 1'b1);
    send(80'h6, 7'd3, 14'd4, 1'b1);
    chk("wrap_frame", 64'(frame_count), 64'(1));
    drain(30);
    check_counts("wrap");

    m_axis_tready = 1'b0;
    for (int i = 0; i < 65560; i++) begin
      set_rand();
      cycle();
    end
    s_axis_tvalid = 1'b0;
    chk("sat_drop", 64'(drop_count), 64'(16'hFFFF));
    m_axis_tready = 1'b1;
    drain(200);
    check_counts("sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
